// File: rtl/local_bht_predictor.sv
// local_bht_predictor: two-level local-history branch predictor with two lookup and two resolve ports
// Ports:
//   clock, reset (async, active-low)
//   two_threads_enable : 1 = tables partitioned by thread id, 0 = everything maps to thread 0
//   if_inst*_pc, inst*_valid, inst*_thread : fetch lookups -> inst*_predict, inst*_predict_valid
//   branch_pc*, branch_result*, branch_valid*, branch_thread* : resolves
//   branch*_mispredict(_valid) : registered, one cycle after the resolve
//   count_clear -> mispredict_count : saturating mispredict total
module local_bht_predictor #(
    parameter int LT_ENTRIES = 32,
    parameter int HIST_BITS  = 5,
    parameter int CTR_BITS   = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                two_threads_enable,
    input  logic [63:0]         if_inst1_pc,
    input  logic [63:0]         if_inst2_pc,
    input  logic                inst1_valid,
    input  logic                inst2_valid,
    input  logic                inst1_thread,
    input  logic                inst2_thread,
    input  logic [63:0]         branch_pc1,
    input  logic [63:0]         branch_pc2,
    input  logic                branch_result1,
    input  logic                branch_result2,
    input  logic                branch_valid1,
    input  logic                branch_valid2,
    input  logic                branch_thread1,
    input  logic                branch_thread2,
    input  logic                count_clear,
    output logic                inst1_predict,
    output logic                inst2_predict,
    output logic                inst1_predict_valid,
    output logic                inst2_predict_valid,
    output logic                branch1_mispredict,
    output logic                branch2_mispredict,
    output logic                branch1_mispredict_valid,
    output logic                branch2_mispredict_valid,
    output logic [CNT_BITS-1:0] mispredict_count
);
    localparam int LW   = $clog2(LT_ENTRIES);
    localparam int ROWS = 2 * LT_ENTRIES;
    localparam int PHTS = 2 ** (HIST_BITS + 1);
    localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [HIST_BITS-1:0] lht [ROWS];
    logic [CTR_BITS-1:0]  pht [PHTS];

    function automatic logic [CTR_BITS-1:0] sat(input logic [CTR_BITS-1:0] c, input logic t);
        return t ? ((c == CTR_MAX) ? c : c + 1'b1) : ((c == '0) ? c : c - 1'b1);
    endfunction

    // lookups: purely from registered state, no bypass of same-cycle resolves
    logic             l1_tid, l2_tid;
    logic [LW:0]      l1_row, l2_row;
    logic [HIST_BITS:0] l1_idx, l2_idx;
    assign l1_tid = two_threads_enable & inst1_thread;
    assign l2_tid = two_threads_enable & inst2_thread;
    assign l1_row = {l1_tid, if_inst1_pc[LW+1:2]};
    assign l2_row = {l2_tid, if_inst2_pc[LW+1:2]};
    assign l1_idx = {l1_tid, lht[l1_row]};
    assign l2_idx = {l2_tid, lht[l2_row]};
    assign inst1_predict       = inst1_valid & pht[l1_idx][CTR_BITS-1];
    assign inst2_predict       = inst2_valid & pht[l2_idx][CTR_BITS-1];
    assign inst1_predict_valid = inst1_valid;
    assign inst2_predict_valid = inst2_valid;

    // resolves: both ports read pre-update state
    logic                 b1_tid, b2_tid;
    logic [LW:0]          b1_row, b2_row;
    logic [HIST_BITS-1:0] b1_hist, b2_hist, h2_base;
    logic [HIST_BITS:0]   b1_idx, b2_idx, h1_ext, h2_ext;
    logic [CTR_BITS-1:0]  b1_ctr, b2_ctr, new_c1, new_c2;
    logic                 same_row, same_ctr;
    assign b1_tid   = two_threads_enable & branch_thread1;
    assign b2_tid   = two_threads_enable & branch_thread2;
    assign b1_row   = {b1_tid, branch_pc1[LW+1:2]};
    assign b2_row   = {b2_tid, branch_pc2[LW+1:2]};
    assign b1_hist  = lht[b1_row];
    assign b2_hist  = lht[b2_row];
    assign b1_idx   = {b1_tid, b1_hist};
    assign b2_idx   = {b2_tid, b2_hist};
    assign b1_ctr   = pht[b1_idx];
    assign b2_ctr   = pht[b2_idx];
    assign same_row = branch_valid1 & branch_valid2 & (b1_row == b2_row);
    assign same_ctr = branch_valid1 & branch_valid2 & (b1_idx == b2_idx);
    // port 2 chains on port 1's result when they collide, so port 1 applies first
    assign h1_ext   = {b1_hist, branch_result1};
    assign h2_base  = same_row ? h1_ext[HIST_BITS-1:0] : b2_hist;
    assign h2_ext   = {h2_base, branch_result2};
    assign new_c1   = sat(b1_ctr, branch_result1);
    assign new_c2   = sat(same_ctr ? new_c1 : b2_ctr, branch_result2);

    logic [CNT_BITS:0] cnt_sum;
    assign cnt_sum = {1'b0, mispredict_count} + {{CNT_BITS{1'b0}}, branch1_mispredict}
                   + {{CNT_BITS{1'b0}}, branch2_mispredict};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) lht[i] <= '0;
            for (int i = 0; i < PHTS; i++) pht[i] <= WEAK_NT;
        end else begin
            if (branch_valid1) begin
                lht[b1_row] <= h1_ext[HIST_BITS-1:0];
                pht[b1_idx] <= new_c1;
            end
            // written after port 1 so the chained value wins on a collision
            if (branch_valid2) begin
                lht[b2_row] <= h2_ext[HIST_BITS-1:0];
                pht[b2_idx] <= new_c2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch1_mispredict       <= 1'b0;
            branch2_mispredict       <= 1'b0;
            branch1_mispredict_valid <= 1'b0;
            branch2_mispredict_valid <= 1'b0;
            mispredict_count         <= '0;
        end else begin
            branch1_mispredict       <= branch_valid1 & (b1_ctr[CTR_BITS-1] ^ branch_result1);
            branch2_mispredict       <= branch_valid2 & (b2_ctr[CTR_BITS-1] ^ branch_result2);
            branch1_mispredict_valid <= branch_valid1;
            branch2_mispredict_valid <= branch_valid2;
            mispredict_count         <= count_clear ? '0 : cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_inst1_pc[63:LW+2], if_inst1_pc[1:0], if_inst2_pc[63:LW+2], if_inst2_pc[1:0],
                              branch_pc1[63:LW+2], branch_pc1[1:0], branch_pc2[63:LW+2], branch_pc2[1:0]};
endmodule

// File: tb/tb_local_bht_predictor.sv
// tb_local_bht_predictor: scoreboard bench for local_bht_predictor with directed vectors
module tb_local_bht_predictor;
    logic        clock = 0, reset = 0, two_threads_enable = 0, count_clear = 0;
    logic [63:0] if_inst1_pc = 0, if_inst2_pc = 0, branch_pc1 = 0, branch_pc2 = 0;
    logic        inst1_valid = 0, inst2_valid = 0, inst1_thread = 0, inst2_thread = 0;
    logic        branch_result1 = 0, branch_result2 = 0, branch_valid1 = 0, branch_valid2 = 0;
    logic        branch_thread1 = 0, branch_thread2 = 0;
    logic        inst1_predict, inst2_predict, inst1_predict_valid, inst2_predict_valid;
    logic        branch1_mispredict, branch2_mispredict, branch1_mispredict_valid, branch2_mispredict_valid;
    logic [15:0] mispredict_count;

    always #5 clock = ~clock;

    local_bht_predictor dut (
        .clock(clock), .reset(reset), .two_threads_enable(two_threads_enable),
        .if_inst1_pc(if_inst1_pc), .if_inst2_pc(if_inst2_pc),
        .inst1_valid(inst1_valid), .inst2_valid(inst2_valid),
        .inst1_thread(inst1_thread), .inst2_thread(inst2_thread),
        .branch_pc1(branch_pc1), .branch_pc2(branch_pc2),
        .branch_result1(branch_result1), .branch_result2(branch_result2),
        .branch_valid1(branch_valid1), .branch_valid2(branch_valid2),
        .branch_thread1(branch_thread1), .branch_thread2(branch_thread2),
        .count_clear(count_clear),
        .inst1_predict(inst1_predict), .inst2_predict(inst2_predict),
        .inst1_predict_valid(inst1_predict_valid), .inst2_predict_valid(inst2_predict_valid),
        .branch1_mispredict(branch1_mispredict), .branch2_mispredict(branch2_mispredict),
        .branch1_mispredict_valid(branch1_mispredict_valid), .branch2_mispredict_valid(branch2_mispredict_valid),
        .mispredict_count(mispredict_count)
    );

    int n_chk = 0, n_fail = 0;
    bit pq1[$], pq2[$], mq1[$], mq2[$];
    bit mm [2][32];
    logic [4:0] hh [2];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output valid with no expected entry queued", nm);
    endfunction

    // monitor: pops the scoreboard whenever an output qualifier is high
    always @(negedge clock) begin
        if (reset) begin
            if (inst1_predict_valid) begin
                if (pq1.size() == 0) unexpected("pred1");
                else chk("pred1", inst1_predict, pq1.pop_front());
            end
            if (inst2_predict_valid) begin
                if (pq2.size() == 0) unexpected("pred2");
                else chk("pred2", inst2_predict, pq2.pop_front());
            end
            if (branch1_mispredict_valid) begin
                if (mq1.size() == 0) unexpected("mp1");
                else chk("mp1", branch1_mispredict, mq1.pop_front());
            end
            if (branch2_mispredict_valid) begin
                if (mq2.size() == 0) unexpected("mp2");
                else chk("mp2", branch2_mispredict, mq2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        two_threads_enable = 0;
        tick();
        chk("rst_mp1", branch1_mispredict, 0);
        chk("rst_mp2", branch2_mispredict, 0);
        chk("rst_mp1_valid", branch1_mispredict_valid, 0);
        chk("rst_mp2_valid", branch2_mispredict_valid, 0);
        chk("rst_count", mispredict_count, 0);
        reset = 1;
        tick();
    endtask

    task automatic look(input logic [63:0] pc1, input logic t1, input bit e1,
                        input logic [63:0] pc2, input logic t2, input bit e2);
        inst1_valid = 1; if_inst1_pc = pc1; inst1_thread = t1; pq1.push_back(e1);
        inst2_valid = 1; if_inst2_pc = pc2; inst2_thread = t2; pq2.push_back(e2);
        tick();
        inst1_valid = 0; inst2_valid = 0;
    endtask

    task automatic res(input bit v1, input logic [63:0] pc1, input logic r1, input logic t1, input bit e1,
                       input bit v2, input logic [63:0] pc2, input logic r2, input logic t2, input bit e2);
        branch_valid1 = v1; branch_pc1 = pc1; branch_result1 = r1; branch_thread1 = t1;
        branch_valid2 = v2; branch_pc2 = pc2; branch_result2 = r2; branch_thread2 = t2;
        if (v1) mq1.push_back(e1);
        if (v2) mq2.push_back(e2);
        tick();
        branch_valid1 = 0; branch_valid2 = 0;
    endtask

    // each thread always resolves against its own prediction, so every resolve mispredicts
    task automatic pump_pair();
        logic r1, r2;
        r1 = !mm[0][hh[0]];
        r2 = !mm[1][hh[1]];
        branch_valid1 = 1; branch_pc1 = 64'h40; branch_thread1 = 0; branch_result1 = r1;
        branch_valid2 = 1; branch_pc2 = 64'h40; branch_thread2 = 1; branch_result2 = r2;
        mq1.push_back(1); mq2.push_back(1);
        mm[0][hh[0]] = r1; hh[0] = {hh[0][3:0], r1};
        mm[1][hh[1]] = r2; hh[1] = {hh[1][3:0], r2};
        tick();
    endtask

    initial begin
        // basic training and independent dual resolves
        do_reset();
        look(64'h40, 0, 0, 64'h44, 0, 0);
        chk("pred_idle", inst1_predict, 0);
        res(1, 64'h40, 1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("cnt_one", mispredict_count, 1);
        look(64'h44, 0, 1, 64'h40, 0, 0);
        res(1, 64'h44, 0, 0, 1, 1, 64'h40, 1, 0, 1);
        tick();
        chk("cnt_three", mispredict_count, 3);
        look(64'h44, 0, 0, 64'h40, 0, 0);

        // same row, same counter: port 1 then port 2
        do_reset();
        res(1, 64'h40, 1, 0, 1, 1, 64'h40, 0, 0, 0);
        look(64'h44, 0, 0, 64'h48, 0, 0);
        res(1, 64'h44, 1, 0, 1, 0, 0, 0, 0, 0);
        res(1, 64'h44, 0, 0, 0, 0, 0, 0, 0, 0);
        res(1, 64'h44, 1, 0, 1, 0, 0, 0, 0, 0);
        look(64'h40, 0, 1, 64'h48, 0, 1);
        chk("cnt_dual", mispredict_count, 3);

        // counter saturation at both ends, stepwise on collisions
        do_reset();
        res(1, 64'h40, 0, 0, 0, 1, 64'h40, 0, 0, 0);
        res(1, 64'h44, 1, 0, 1, 0, 0, 0, 0, 0);
        look(64'h48, 0, 0, 64'h40, 0, 0);
        res(1, 64'h50, 1, 0, 1, 1, 64'h50, 1, 0, 1);
        res(1, 64'h54, 1, 0, 0, 1, 64'h54, 1, 0, 0);
        res(1, 64'h58, 0, 0, 1, 0, 0, 0, 0, 0);
        look(64'h5C, 0, 1, 64'h60, 0, 1);

        // thread partitioning
        do_reset();
        two_threads_enable = 1;
        repeat (3) res(1, 64'h80, 1, 1, 1, 0, 0, 0, 0, 0);
        look(64'h84, 1, 1, 64'h80, 0, 0);
        look(64'h80, 1, 0, 64'h84, 0, 0);
        two_threads_enable = 0;
        look(64'h84, 1, 0, 64'h80, 1, 0);

        // reset right after a resolve drops the pending mispredict
        do_reset();
        branch_valid1 = 1; branch_pc1 = 64'h40; branch_result1 = 1; branch_thread1 = 0;
        @(posedge clock);
        #1;
        reset = 0;
        branch_valid1 = 0;
        tick();
        reset = 1;
        chk("rst_mid_valid", branch1_mispredict_valid, 0);
        tick();
        chk("rst_mid_valid2", branch1_mispredict_valid, 0);
        res(1, 64'h40, 1, 0, 1, 0, 0, 0, 0, 0);
        look(64'h44, 0, 1, 64'h40, 0, 0);

        // mispredict_count saturation and clear
        do_reset();
        two_threads_enable = 1;
        for (int t = 0; t < 2; t++) begin
            hh[t] = '0;
            for (int i = 0; i < 32; i++) mm[t][i] = 0;
        end
        for (int i = 0; i < 32767; i++) pump_pair();
        branch_valid1 = 0; branch_valid2 = 0;
        tick();
        tick();
        chk("cnt_fffe", mispredict_count, 16'hFFFE);
        pump_pair();
        branch_valid1 = 0; branch_valid2 = 0;
        tick();
        chk("cnt_sat", mispredict_count, 16'hFFFF);
        pump_pair();
        branch_valid1 = 0; branch_valid2 = 0;
        count_clear = 1;
        tick();
        count_clear = 0;
        chk("cnt_clear", mispredict_count, 0);
        tick();

        chk("pq1_drain", pq1.size(), 0);
        chk("pq2_drain", pq2.size(), 0);
        chk("mq1_drain", mq1.size(), 0);
        chk("mq2_drain", mq2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/local_bht_predictor.md
LOCAL_BHT_PREDICTOR -- requirements
Module: local_bht_predictor

Interface
REQ-001 SHALL have parameter LT_ENTRIES, default 32: local-history-table rows per thread, power of 2, at least 2.
REQ-002 SHALL have parameter HIST_BITS, default 5: local history length; each thread's pattern table has 2^HIST_BITS counters.
REQ-003 SHALL have parameter CTR_BITS, default 2: saturating counter width, at least 2.
REQ-004 SHALL have parameter CNT_BITS, default 16: mispredict counter width.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low; state clears while reset=0.
- two_threads_enable  in  1  1 = per-thread partitioned tables; 0 = thread inputs ignored, thread 0 used.
- if_inst1_pc / if_inst2_pc  in  64  fetch PCs for lookup.
- inst1_valid / inst2_valid  in  1  lookup request.
- inst1_thread / inst2_thread  in  1  thread id of the lookup.
- branch_pc1 / branch_pc2  in  64  resolved branch PC.
- branch_result1 / branch_result2  in  1  1 = taken.
- branch_valid1 / branch_valid2  in  1  resolve request.
- branch_thread1 / branch_thread2  in  1  thread id of the resolve.
- count_clear  in  1  synchronous clear of mispredict_count.
- inst1_predict / inst2_predict  out  1  predicted direction.
- inst1_predict_valid / inst2_predict_valid  out  1  prediction qualifier.
- branch1_mispredict / branch2_mispredict  out  1  resolve disagreed with the prediction state.
- branch1_mispredict_valid / branch2_mispredict_valid  out  1  qualifier for the mispredict output.
- mispredict_count  out  CNT_BITS  saturating total of mispredicts.

Function
REQ-006 The effective thread tid SHALL equal the thread input when two_threads_enable=1, and 0 otherwise.
REQ-007 The LHT row SHALL be {tid, pc[log2(LT_ENTRIES)+1:2]}; the PHT index SHALL be {tid, history of that row}.
REQ-008 Lookup SHALL be combinational from registered state only, with no bypass of same-cycle resolves.
- inst*_predict SHALL equal the MSB of the indexed counter when inst*_valid=1, and 0 otherwise.
- inst*_predict_valid SHALL equal inst*_valid.
REQ-009 On a resolve, the row history SHALL become {history[HIST_BITS-2:0], result}.
REQ-010 On a resolve, the indexed counter SHALL increment on taken and decrement on not-taken, saturating at all-ones and zero.
REQ-011 branch*_mispredict SHALL be (counter MSB != result), computed from pre-update state.
- It SHALL be registered: valid is asserted exactly 1 cycle after branch*_valid and held for 1 cycle.
- This SHALL happen whether or not the counter saturates.
REQ-012 When both resolve ports hit the same LHT row in one cycle, port 1 then port 2 SHALL apply.
- New history SHALL be {history[HIST_BITS-3:0], result1, result2}.
- If HIST_BITS=1, new history SHALL be {result2}.
REQ-013 When both resolve ports hit the same PHT counter in one cycle, the updates SHALL apply sequentially, port 1 then port 2, each step saturating.
- Both mispredict outputs SHALL still use the pre-update counter.
REQ-014 Resolves on different rows or counters SHALL update independently in the same cycle.
REQ-015 mispredict_count SHALL add 0, 1 or 2 per cycle (the number of registered mispredicts asserted that cycle) and saturate at all-ones.
- count_clear SHALL have priority and load 0.
REQ-016 A resolve when both the row and thread mismatch a concurrent fetch lookup SHALL not affect that lookup's result.

Reset
REQ-017 While reset=0, every history SHALL be 0.
REQ-018 While reset=0, every counter SHALL be weakly not-taken, 2^(CTR_BITS-1)-1.
REQ-019 While reset=0, mispredict outputs and qualifiers SHALL be 0 and mispredict_count SHALL be 0.
REQ-020 A reset assertion mid-operation SHALL discard pending registered mispredicts; the first cycle after release SHALL show valid=0.

Verification
REQ-021 Bench SHALL cover, with defaults:
- After reset, lookup pc=0x40 -> predict=0, predict_valid=1.
- Resolve pc=0x40 taken once -> next cycle branch1_mispredict=1, valid=1; row 16 history=00001; counter[0] 01->10; count=1.
- Resolve pc=0x40 on both ports, taken and not-taken -> row history gets bits 1,0; counter[0] 01->10->01; mispredict1=1, mispredict2=0.
- two_threads_enable=1, thread 1 trains pc=0x80 taken x3 -> thread 1 predicts 1 after the trained pattern is reached; thread 0 lookup of 0x80 stays 0.
- Force mispredict_count to all-ones minus 1, then two mispredicts in one cycle -> saturates at 0xFFFF; count_clear in the same cycle -> 0.
- reset driven low one cycle after a resolve -> mispredict_valid never asserted; all counters return to 01.
